// File: rtl/psum_accumulator_pkg.sv
// rtl/psum_accumulator_pkg.sv - shared types and saturating add for the partial-sum accumulator
package psum_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } acc_state_t;

    // Wide enough that a + b never overflows before clamping to the target width
    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             width
    );
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// rtl/psum_accumulator_if.sv - product input stream and partial-sum output handshake
interface psum_accumulator_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20
);
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         in_stall;
    logic                         in_done;
    logic                         in_co_filter;
    logic                         in_clear;
    logic                         stall_req;
    logic signed [ACC_WIDTH-1:0]  psum_out;
    logic                         psum_valid;
    logic                         psum_ready;

    modport master (
        output in_data, in_stall, in_done, in_co_filter, in_clear, psum_ready,
        input  stall_req, psum_out, psum_valid
    );

    modport slave (
        input  in_data, in_stall, in_done, in_co_filter, in_clear, psum_ready,
        output stall_req, psum_out, psum_valid
    );
endinterface

// File: rtl/psum_accumulator_fifo2.sv
// rtl/psum_accumulator_fifo2.sv - two-entry in-order buffer with push/pop/clear and occupancy
module psum_accumulator_fifo2 #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_idx;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (count != 2'd0);
    // A full buffer still takes a push when the head leaves in the same cycle
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign wr_idx  = rd_ptr ^ count[0];
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_idx] <= push_data;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - per-window saturating product accumulator with buffered partial-sum output
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    psum_accumulator_if.slave    bus,
    output logic                 done_out,
    output logic                 err_partial,
    output logic [CNT_WIDTH-1:0] win_cnt
);
    acc_state_t                  state;
    acc_state_t                  state_nxt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [SAT_W-1:0]     acc_term;
    logic                        first;
    logic [1:0]                  occ;
    logic [ACC_WIDTH-1:0]        head;
    logic                        beat;
    logic                        accept;
    logic                        push;
    logic                        pop;

    // Backpressure comes from registered occupancy only, never from psum_ready
    assign bus.stall_req  = (occ == 2'd2);
    assign bus.psum_valid = (occ != 2'd0);
    assign bus.psum_out   = head;

    assign beat   = !bus.in_stall && !bus.stall_req;
    assign accept = beat && (state != DRAIN);
    assign push   = accept && bus.in_co_filter;
    assign pop    = bus.psum_valid && bus.psum_ready;

    assign acc_term = first ? {SAT_W{1'b0}} : SAT_W'(acc);
    assign sum      = ACC_WIDTH'(sat_add(SAT_W'(bus.in_data), acc_term, ACC_WIDTH));

    psum_accumulator_fifo2 #(
        .WIDTH (ACC_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (sum),
        .pop       (pop),
        .clear     (bus.in_clear),
        .head      (head),
        .count     (occ)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_out  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = bus.in_done ? DRAIN : ACC;
                end
            end
            ACC: begin
                if (accept && bus.in_done) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (occ == 2'd0) begin
                    state_nxt = IDLE;
                    done_out  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.in_clear) begin
            state_nxt = IDLE;
            done_out  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc         <= '0;
            first       <= 1'b1;
            win_cnt     <= '0;
            err_partial <= 1'b0;
        end else if (bus.in_clear) begin
            acc         <= '0;
            first       <= 1'b1;
            win_cnt     <= '0;
            err_partial <= 1'b0;
        end else if (accept) begin
            if (bus.in_co_filter) begin
                acc     <= '0;
                first   <= 1'b1;
                win_cnt <= win_cnt + CNT_WIDTH'(1);
            end else if (bus.in_done) begin
                // Job ended mid-window: the partial sum is dropped, never emitted
                acc         <= '0;
                first       <= 1'b1;
                err_partial <= 1'b1;
            end else begin
                acc   <= sum;
                first <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - directed bench with a queue-based reference model for psum_accumulator
module tb_psum_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    psum_accumulator_if #(.DATA_WIDTH(8), .ACC_WIDTH(20)) bus0 ();
    psum_accumulator_if #(.DATA_WIDTH(8), .ACC_WIDTH(9))  bus1 ();

    logic        done0, done1, err0, err1;
    logic [15:0] win0, win1;

    psum_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(20), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave),
        .done_out(done0), .err_partial(err0), .win_cnt(win0)
    );

    psum_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(9), .CNT_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave),
        .done_out(done1), .err_partial(err1), .win_cnt(win1)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: one window sum per accumulator width, queues stand for the output buffer
    longint q0[$];
    longint q1[$];
    longint acc0 = 0, acc1 = 0, s0, s1;
    bit     m_first = 1'b1, m_drain = 1'b0, m_err = 1'b0;
    int     m_win = 0;
    bit     m_full, m_beat, m_pop, m_empty;

    function automatic longint clamp(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q0.delete(); q1.delete();
            acc0 = 0; acc1 = 0; m_first = 1'b1; m_drain = 1'b0; m_err = 1'b0; m_win = 0;
        end else if (bus0.in_clear) begin
            q0.delete(); q1.delete();
            acc0 = 0; acc1 = 0; m_first = 1'b1; m_drain = 1'b0; m_err = 1'b0; m_win = 0;
        end else begin
            m_full  = (q0.size() == 2);
            m_empty = (q0.size() == 0);
            m_beat  = !bus0.in_stall && !m_full;
            m_pop   = !m_empty && bus0.psum_ready;
            if (m_pop) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (m_drain) begin
                if (m_empty) m_drain = 1'b0;
            end else if (m_beat) begin
                s0 = clamp((m_first ? 0 : acc0) + bus0.in_data, 20);
                s1 = clamp((m_first ? 0 : acc1) + bus1.in_data, 9);
                if (bus0.in_co_filter) begin
                    q0.push_back(s0); q1.push_back(s1);
                    acc0 = 0; acc1 = 0; m_first = 1'b1;
                    m_win = (m_win + 1) % 65536;
                end else if (bus0.in_done) begin
                    acc0 = 0; acc1 = 0; m_first = 1'b1; m_err = 1'b1;
                end else begin
                    acc0 = s0; acc1 = s1; m_first = 1'b0;
                end
                if (bus0.in_done) m_drain = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("psum_valid0", bus0.psum_valid, q0.size() > 0);
            check("psum_valid1", bus1.psum_valid, q1.size() > 0);
            check("stall_req0", bus0.stall_req, q0.size() == 2);
            check("stall_req1", bus1.stall_req, q1.size() == 2);
            if (q0.size() > 0) check("psum_out0", bus0.psum_out, q0[0]);
            if (q1.size() > 0) check("psum_out1", bus1.psum_out, q1[0]);
            check("win_cnt0", win0, m_win);
            check("win_cnt1", win1, m_win);
            check("err_partial0", err0, m_err);
            check("done_out0", done0, m_drain && (q0.size() == 0) && !bus0.in_clear);
            check("done_out1", done1, m_drain && (q1.size() == 0) && !bus1.in_clear);
        end
    end

    task automatic drive(input int data, input bit stall, input bit done, input bit co,
                         input bit clr, input bit rdy);
        bus0.in_data = 8'(data);  bus1.in_data = 8'(data);
        bus0.in_stall = stall;    bus1.in_stall = stall;
        bus0.in_done = done;      bus1.in_done = done;
        bus0.in_co_filter = co;   bus1.in_co_filter = co;
        bus0.in_clear = clr;      bus1.in_clear = clr;
        bus0.psum_ready = rdy;    bus1.psum_ready = rdy;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic clear_all();
        drive(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        idle(1'b1);
    endtask

    initial begin
        bit seen;
        idle(1'b1);
        rst = 1'b0;
        tick(); tick();
        check("reset_psum_valid", bus0.psum_valid, 0);
        check("reset_stall_req", bus0.stall_req, 0);
        check("reset_win_cnt", win0, 0);
        check("reset_err_partial", err0, 0);
        check("reset_done_out", done0, 0);
        rst = 1'b1;
        chk_en = 1'b1;
        tick();

        // 9 beats of +1, window closes on the 9th
        for (int i = 1; i <= 9; i++) begin
            drive(1, 1'b0, 1'b0, i == 9, 1'b0, 1'b1);
            tick();
        end
        check("t1_psum_out", bus0.psum_out, 9);
        check("t1_psum_valid", bus0.psum_valid, 1);
        check("t1_win_cnt", win0, 1);
        idle(1'b1); tick();
        check("t1_drained", bus0.psum_valid, 0);

        // Backpressure with three single-beat windows
        clear_all();
        drive(10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        check("t2_stall_full", bus0.stall_req, 1);
        check("t2_head_first", bus0.psum_out, 10);
        drive(30, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick(); tick();
        check("t2_third_held", win0, 2);
        drive(30, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); tick();
        check("t2_head_second", bus0.psum_out, 20);
        check("t2_stall_drop", bus0.stall_req, 0);
        tick();
        check("t2_head_third", bus0.psum_out, 30);
        check("t2_win_cnt", win0, 3);
        idle(1'b1); tick();
        check("t2_empty", bus0.psum_valid, 0);

        // Saturation at both rails on the 9-bit instance
        for (int i = 1; i <= 3; i++) begin
            drive(127, 1'b0, 1'b0, i == 3, 1'b0, 1'b1); tick();
        end
        check("t3_sat_max", bus1.psum_out, 255);
        check("t3_wide_pos", bus0.psum_out, 381);
        for (int i = 1; i <= 3; i++) begin
            drive(-128, 1'b0, 1'b0, i == 3, 1'b0, 1'b1); tick();
        end
        check("t3_sat_min", bus1.psum_out, -256);
        check("t3_wide_neg", bus0.psum_out, -384);
        idle(1'b1); tick();

        // Job ends on beat 4 of a 9-tap window
        clear_all();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1'b0, i == 4, 1'b0, 1'b0, 1'b1); tick();
        end
        check("t4_err_partial", err0, 1);
        check("t4_no_psum", bus0.psum_valid, 0);
        check("t4_done_pulse", done0, 1);
        idle(1'b1); tick();
        check("t4_done_once", done0, 0);

        // Done on a closing beat while the consumer stalls; DRAIN ignores later beats
        clear_all();
        drive(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
        drive(9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick(); tick();
        check("t4b_drain_ignores", win0, 1);
        check("t4b_psum", bus0.psum_out, 4);
        check("t4b_no_done_yet", done0, 0);
        idle(1'b1);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            if (done0) seen = 1'b1;
        end
        check("t4b_done_seen", seen, 1);
        check("t4b_no_err", err0, 0);
        idle(1'b1); tick();

        // Clear wins over a same-cycle beat and pop
        clear_all();
        drive(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); tick();
        check("t5a_valid", bus0.psum_valid, 0);
        check("t5a_win", win0, 0);
        drive(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick(); tick();
        check("t5b_full", bus0.stall_req, 1);
        drive(7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); tick();
        check("t5b_stall", bus0.stall_req, 0);
        check("t5b_valid", bus0.psum_valid, 0);
        check("t5b_win", win0, 0);
        drive(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); tick();
        check("t5c_fresh_acc", bus0.psum_out, 3);
        idle(1'b1); tick();

        // Asynchronous reset mid-window
        drive(4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick(); tick();
        idle(1'b1);
        rst = 1'b0;
        tick();
        check("t6_rst_valid", bus0.psum_valid, 0);
        check("t6_rst_win", win0, 0);
        rst = 1'b1;
        drive(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); tick();
        check("t6_psum", bus0.psum_out, 3);
        check("t6_valid", bus0.psum_valid, 1);
        idle(1'b1); tick(); tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
